// File: rtl/guess_game_pkg.sv
// Shared types and default parameters for the parametrised guessing game.
package guess_game_pkg;

   localparam int DEF_GUESS_W      = 8;
   localparam int DEF_RANGE_MAX    = 99;
   localparam int DEF_MAX_ATTEMPTS = 7;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE} state_t;
   typedef enum logic [1:0] {CMP_UNDER, CMP_EQUAL, CMP_OVER} cmp_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input; one pulse per low-to-high transition.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_level,
   output logic o_pulse
);

   logic level_q, level_d;

   always_comb level_d = i_level;

   always_ff @(posedge clk) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level_d;
   end

   // Combinational so the press is acted on at the same edge it is seen.
   assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/guess_game_param.sv
// Number-guessing game engine: free-running secret counter, comparator and game FSM.
module guess_game_param
   import guess_game_pkg::*;
#(
   parameter int GUESS_W      = DEF_GUESS_W,
   parameter int RANGE_MAX    = DEF_RANGE_MAX,
   parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
   parameter int ATT_W        = $clog2(MAX_ATTEMPTS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [GUESS_W-1:0] i_guess,
   input  logic               i_enter,
   output logic               o_under,
   output logic               o_over,
   output logic               o_equal,
   output logic               o_update_leds,
   output logic [ATT_W-1:0]   o_remaining_attempts,
   output logic               o_win,
   output logic               o_lose
);

   localparam logic [GUESS_W-1:0] RMAX_V = GUESS_W'(RANGE_MAX);
   localparam logic [ATT_W-1:0]   MAX_V  = ATT_W'(MAX_ATTEMPTS);

   state_t             state_q, state_d;
   logic [GUESS_W-1:0] cnt_q, cnt_d;
   logic [GUESS_W-1:0] secret_q, secret_d;
   logic [ATT_W-1:0]   rem_q, rem_d, rem_dec;
   logic               under_q, under_d, over_q, over_d, equal_q, equal_d;
   logic               win_q, win_d, lose_q, lose_d, upd_q, upd_d;
   logic               press;
   cmp_t               cmp;

   rise_detect u_enter_rise (
      .clk     (clk),
      .reset   (reset),
      .i_level (i_enter),
      .o_pulse (press)
   );

   always_comb begin
      if (i_guess < secret_q)      cmp = CMP_UNDER;
      else if (i_guess > secret_q) cmp = CMP_OVER;
      else                         cmp = CMP_EQUAL;
   end

   assign rem_dec = (rem_q == '0) ? '0 : rem_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      secret_d = secret_q;
      rem_d    = rem_q;
      under_d  = under_q;
      over_d   = over_q;
      equal_d  = equal_q;
      win_d    = win_q;
      lose_d   = lose_q;
      upd_d    = 1'b0;
      cnt_d    = (cnt_q == RMAX_V) ? '0 : cnt_q + 1'b1;

      if (press) begin
         unique case (state_q)
            S_IDLE: begin
               secret_d = cnt_q;
               state_d  = S_PLAY;
            end
            S_PLAY: begin
               under_d = (cmp == CMP_UNDER);
               over_d  = (cmp == CMP_OVER);
               equal_d = (cmp == CMP_EQUAL);
               rem_d   = rem_dec;
               upd_d   = 1'b1;
               if (cmp == CMP_EQUAL) begin
                  state_d = S_WIN;
                  win_d   = 1'b1;
               end else if (rem_dec == '0) begin
                  state_d = S_LOSE;
                  lose_d  = 1'b1;
               end
            end
            S_WIN, S_LOSE: begin
               // Restart: the strobe lets the LED controllers clear.
               state_d = S_IDLE;
               under_d = 1'b0;
               over_d  = 1'b0;
               equal_d = 1'b0;
               win_d   = 1'b0;
               lose_d  = 1'b0;
               rem_d   = MAX_V;
               upd_d   = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         secret_q <= '0;
         rem_q    <= MAX_V;
         under_q  <= 1'b0;
         over_q   <= 1'b0;
         equal_q  <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         secret_q <= secret_d;
         rem_q    <= rem_d;
         under_q  <= under_d;
         over_q   <= over_d;
         equal_q  <= equal_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
         upd_q    <= upd_d;
      end
   end

   assign o_under              = under_q;
   assign o_over               = over_q;
   assign o_equal              = equal_q;
   assign o_update_leds        = upd_q;
   assign o_remaining_attempts = rem_q;
   assign o_win                = win_q;
   assign o_lose               = lose_q;

endmodule

// File: tb/tb_guess_game_param.sv
// Bench for guess_game_param: three configurations share one stimulus and an event-level game model.
module tb_guess_game_param;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       enter = 1'b0;
   logic [7:0] guess = 8'd0;

   always #5 clk = ~clk;

   // inst0: defaults (8,99,7); inst1: (4,15,15); inst2: (8,99,3)
   logic       u0, o0, e0, up0, w0, l0;
   logic [2:0] r0;
   logic       u1, o1, e1, up1, w1, l1;
   logic [3:0] r1;
   logic       u2, o2, e2, up2, w2, l2;
   logic [1:0] r2;

   guess_game_param u_dut0 (
      .clk(clk), .reset(reset), .i_guess(guess), .i_enter(enter),
      .o_under(u0), .o_over(o0), .o_equal(e0), .o_update_leds(up0),
      .o_remaining_attempts(r0), .o_win(w0), .o_lose(l0));

   guess_game_param #(.GUESS_W(4), .RANGE_MAX(15), .MAX_ATTEMPTS(15)) u_dut1 (
      .clk(clk), .reset(reset), .i_guess(guess[3:0]), .i_enter(enter),
      .o_under(u1), .o_over(o1), .o_equal(e1), .o_update_leds(up1),
      .o_remaining_attempts(r1), .o_win(w1), .o_lose(l1));

   guess_game_param #(.MAX_ATTEMPTS(3)) u_dut2 (
      .clk(clk), .reset(reset), .i_guess(guess), .i_enter(enter),
      .o_under(u2), .o_over(o2), .o_equal(e2), .o_update_leds(up2),
      .o_remaining_attempts(r2), .o_win(w2), .o_lose(l2));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   int strobes0 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: game phase 0=idle 1=playing 2=won 3=lost, one entry per instance.
   localparam int RMAX [3] = '{99, 15, 99};
   localparam int MATT [3] = '{7, 15, 3};
   localparam int GMSK [3] = '{255, 15, 255};

   int m_cnt [3];
   int m_sec [3];
   int m_rem [3];
   int m_phase [3];
   bit m_u [3], m_o [3], m_e [3], m_w [3], m_l [3], m_up [3];
   bit m_prev;

   always @(posedge clk) begin
      bit pr;
      int g;
      pr = enter && !m_prev;
      for (int i = 0; i < 3; i++) begin
         m_up[i] = 1'b0;
         if (reset) begin
            m_cnt[i] = 0; m_sec[i] = 0; m_rem[i] = MATT[i]; m_phase[i] = 0;
            m_u[i] = 0; m_o[i] = 0; m_e[i] = 0; m_w[i] = 0; m_l[i] = 0;
         end else begin
            if (pr) begin
               if (m_phase[i] == 0) begin
                  m_sec[i] = m_cnt[i];
                  m_phase[i] = 1;
               end else if (m_phase[i] == 1) begin
                  g = int'(guess) & GMSK[i];
                  m_u[i] = g < m_sec[i];
                  m_o[i] = g > m_sec[i];
                  m_e[i] = g == m_sec[i];
                  m_rem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : 0;
                  m_up[i] = 1'b1;
                  if (m_e[i]) begin m_phase[i] = 2; m_w[i] = 1'b1; end
                  else if (m_rem[i] == 0) begin m_phase[i] = 3; m_l[i] = 1'b1; end
               end else begin
                  m_phase[i] = 0; m_rem[i] = MATT[i]; m_up[i] = 1'b1;
                  m_u[i] = 0; m_o[i] = 0; m_e[i] = 0; m_w[i] = 0; m_l[i] = 0;
               end
            end
            m_cnt[i] = (m_cnt[i] + 1) % (RMAX[i] + 1);
         end
      end
      m_prev = reset ? 1'b0 : enter;
   end

   function automatic logic [31:0] pack(input logic u, o, e, up, w, l, input logic [7:0] rem);
      return {18'd0, u, o, e, up, w, l, rem};
   endfunction

   function automatic logic [31:0] model_vec(input int i);
      return pack(m_u[i], m_o[i], m_e[i], m_up[i], m_w[i], m_l[i], 8'(m_rem[i]));
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_inst0", pack(u0, o0, e0, up0, w0, l0, {5'd0, r0}), model_vec(0));
         check("cyc_inst1", pack(u1, o1, e1, up1, w1, l1, {4'd0, r1}), model_vec(1));
         check("cyc_inst2", pack(u2, o2, e2, up2, w2, l2, {6'd0, r2}), model_vec(2));
         if (up0) strobes0++;
      end
   end

   task automatic do_reset();
      @(negedge clk); reset = 1'b1; enter = 1'b0;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic press(input logic [7:0] g);
      @(negedge clk); guess = g; enter = 1'b1;
      @(negedge clk); enter = 1'b0;
   endtask

   // Press at the edge where instance idx's secret counter reads target.
   task automatic press_at(input int idx, input int target, input logic [7:0] g);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_cnt[idx] != target && n < 300);
      if (n >= 300) check("press_at_timeout", 32'd0, 32'd1);
      guess = g; enter = 1'b1;
      @(negedge clk); enter = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_rem0", 32'(r0), 32'd7);
      check("rst_rem1", 32'(r1), 32'd15);
      check("rst_flags0", {26'd0, u0, o0, e0, up0, w0, l0}, 32'd0);
      reset = 1'b0;

      // basic game, secret 42
      press_at(0, 42, 8'd0);
      check("start_no_strobe", 32'(up0), 32'd0);
      press(8'd50);
      check("basic_over", {29'd0, u0, o0, e0}, 32'b010);
      check("basic_rem6", 32'(r0), 32'd6);
      press(8'd30);
      check("basic_under", {29'd0, u0, o0, e0}, 32'b100);
      check("basic_rem5", 32'(r0), 32'd5);
      press(8'd42);
      check("basic_equal", {29'd0, u0, o0, e0}, 32'b001);
      check("basic_win", {30'd0, w0, up0}, 32'b11);
      check("basic_rem4", 32'(r0), 32'd4);
      press(8'd0);
      check("restart_clear", {25'd0, u0, o0, e0, w0, l0, up0, 1'b0}, 32'b10);
      check("restart_rem", 32'(r0), 32'd7);

      // lose path on the 3-attempt instance, secret 10
      do_reset();
      press_at(2, 10, 8'd0);
      press(8'd0); check("lose_rem2", 32'(r2), 32'd2);
      press(8'd0); check("lose_rem1", 32'(r2), 32'd1);
      press(8'd0); check("lose_rem0", 32'(r2), 32'd0);
      check("lose_flag", {30'd0, l2, u2}, 32'b11);
      press(8'd0);
      check("lose_restart_rem", 32'(r2), 32'd3);
      check("lose_restart_flags", {27'd0, u2, o2, e2, w2, l2}, 32'd0);

      // held button: one guess only
      do_reset();
      press_at(0, 42, 8'd0);
      strobes0 = 0;
      @(negedge clk); guess = 8'd0; enter = 1'b1;
      repeat (20) @(negedge clk);
      enter = 1'b0;
      @(negedge clk);
      check("held_rem", 32'(r0), 32'd6);
      check("held_strobes", 32'(strobes0), 32'd1);

      // wrap: capture at counter 99, out-of-range guess
      do_reset();
      press_at(0, 99, 8'd0);
      press(8'd200);
      check("range_over", {29'd0, u0, o0, e0}, 32'b010);
      check("range_rem", 32'(r0), 32'd6);
      press(8'd99);
      check("wrap_secret99", {30'd0, e0, w0}, 32'b11);

      // reset mid-game coincident with a press
      do_reset();
      press_at(0, 5, 8'd0);
      press(8'd10);
      press(8'd20);
      @(negedge clk); reset = 1'b1; enter = 1'b1; guess = 8'd5;
      @(negedge clk); reset = 1'b0; enter = 1'b0;
      check("midrst_rem", 32'(r0), 32'd7);
      check("midrst_flags", {26'd0, u0, o0, e0, up0, w0, l0}, 32'd0);
      press(8'd5);
      check("midrst_idle_start", {31'd0, up0}, 32'd0);

      // 4-bit instance: secret 15, guess 4'hF
      do_reset();
      check("w4_rem15", 32'(r1), 32'd15);
      press_at(1, 15, 8'd0);
      press(8'hFF);
      check("w4_equal", {29'd0, u1, e1, w1}, 32'b011);
      check("w4_rem14", 32'(r1), 32'd14);

      // randomized play, occasional resets
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 149) == 0);
         enter = ($urandom_range(0, 2) == 0);
         guess = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      end
      @(negedge clk); reset = 1'b0; enter = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
